// File: rtl/divider_pkg.sv
// Shared widths and FSM encoding for the restoring shift-subtract divider.
package divider_pkg;
    localparam int DIV_W = 8;
    localparam int ITER  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/HexDriver.sv
// Nibble to active-low seven-segment pattern (gfedcba), purely combinational.
module HexDriver (
    input  logic [3:0] In0,
    output logic [6:0] Out0
);
    always_comb begin
        Out0 = 7'b1111111;
        case (In0)
            4'h0: Out0 = 7'b1000000;
            4'h1: Out0 = 7'b1111001;
            4'h2: Out0 = 7'b0100100;
            4'h3: Out0 = 7'b0110000;
            4'h4: Out0 = 7'b0011001;
            4'h5: Out0 = 7'b0010010;
            4'h6: Out0 = 7'b0000010;
            4'h7: Out0 = 7'b1111000;
            4'h8: Out0 = 7'b0000000;
            4'h9: Out0 = 7'b0010000;
            4'hA: Out0 = 7'b0001000;
            4'hB: Out0 = 7'b0000011;
            4'hC: Out0 = 7'b1000110;
            4'hD: Out0 = 7'b0100001;
            4'hE: Out0 = 7'b0000110;
            default: Out0 = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/restoring_divider_trial_subtractor.sv
// Combinational trial subtraction R9 - D at 10 bits; borrow set when D > R9.
// Zero latency; no handshake.
module trial_subtractor
    import divider_pkg::*;
(
    input  logic [DIV_W:0]   i_r9,
    input  logic [DIV_W-1:0] i_d,
    output logic [DIV_W:0]   o_diff,
    output logic             o_borrow
);
    logic [DIV_W+1:0] w_trial;

    assign w_trial  = {1'b0, i_r9} - {2'b00, i_d};
    assign o_diff   = w_trial[DIV_W:0];
    assign o_borrow = w_trial[DIV_W+1];
endmodule

// File: rtl/restoring_divider.sv
// 8-bit unsigned restoring divider: quotient left in Q, remainder in R.
// 17 clocks from the Run sample to a valid result; one division per Run press.
module restoring_divider
    import divider_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic [DIV_W-1:0] S,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    output logic [6:0]       AhexU,
    output logic [6:0]       AhexL,
    output logic [6:0]       BhexU,
    output logic [6:0]       BhexL,
    output logic [DIV_W-1:0] Aval,
    output logic [DIV_W-1:0] Bval,
    output logic             DivZero,
    output logic             Busy,
    output logic             shift,
    output logic             sub
);
    state_t           r_state, w_next;
    logic [DIV_W:0]   r_r9;
    logic [DIV_W-1:0] r_q, r_d;
    logic [2:0]       r_cnt;
    logic             r_divzero;
    logic [DIV_W:0]   w_diff;
    logic             w_borrow;

    trial_subtractor u_trial (
        .i_r9     (r_r9),
        .i_d      (r_d),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (!Run) w_next = SHIFT;
            SHIFT: w_next = SUB;
            SUB:   w_next = (r_cnt == 3'(ITER - 1)) ? DONE : SHIFT;
            DONE:  if (Run) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Run takes priority over load when both buttons are held in IDLE.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_r9      <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!Run) begin
                        r_d       <= S;
                        r_r9      <= '0;
                        r_divzero <= (S == '0);
                        r_cnt     <= '0;
                    end else if (!ClearA_LoadB) begin
                        r_q       <= S;
                        r_r9      <= '0;
                        r_divzero <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_r9 <= {r_r9[DIV_W-1:0], r_q[DIV_W-1]};
                    r_q  <= {r_q[DIV_W-2:0], 1'b0};
                end
                SUB: begin
                    if (!w_borrow) begin
                        r_r9   <= w_diff;
                        r_q[0] <= 1'b1;
                    end
                    r_cnt <= r_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign Aval    = r_r9[DIV_W-1:0];
    assign Bval    = r_q;
    assign DivZero = r_divzero;
    assign Busy    = (r_state == SHIFT) || (r_state == SUB);
    assign shift   = (r_state == SHIFT);
    assign sub     = (r_state == SUB);

    HexDriver u_hex_au (.In0(r_r9[7:4]), .Out0(AhexU));
    HexDriver u_hex_al (.In0(r_r9[3:0]), .Out0(AhexL));
    HexDriver u_hex_bu (.In0(r_q[7:4]),  .Out0(BhexU));
    HexDriver u_hex_bl (.In0(r_q[3:0]),  .Out0(BhexL));
endmodule
